hex_word_assembler: RTL

- Consumes the ASCII byte stream from the UART receiver and decodes hex digits to nibbles using the standard ASCII-hex mapping.
- Shifts the nibbles into a DATA_W-bit word and presents the completed word to the command/register-write logic when a line terminator arrives.
- Rejects malformed lines (non-hex characters, too many digits) and reports them.
- Sits between the UART RX byte output and the host command decoder.

---
 rtl/hex_word_assembler.sv | 129 ++++++++++++
 1 files changed

// File: rtl/hex_word_assembler.sv
// Assembles ASCII hex digits from a UART byte stream into DATA_W-bit words, one word per terminated line.
// Optional byte echo (lowercase hex folded to uppercase) is enabled by defining HEX_ASSEMBLER_ECHO_EN.
module hex_word_assembler #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NIB_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [DATA_W-1:0] word_out,
  output logic [NIB_W-1:0]  word_nibbles,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              err_pulse,
  output logic              overrun,
  output logic [7:0]        echo_data,
  output logic              echo_valid
);

  localparam int unsigned DIGITS = DATA_W / 4;

  typedef enum logic [1:0] {IDLE, ACCUM, DISCARD, HOLD} state_t;

  state_t            state;
  logic [DATA_W-1:0] acc;
  logic [NIB_W-1:0]  count;

  logic       is_hex;
  logic       is_term;
  logic       is_space;
  logic [3:0] nib;

  always_comb begin
    is_hex   = ((rx_data >= 8'h30) && (rx_data <= 8'h39)) ||
               ((rx_data >= 8'h41) && (rx_data <= 8'h46)) ||
               ((rx_data >= 8'h61) && (rx_data <= 8'h66));
    is_term  = (rx_data == 8'h0D) || (rx_data == 8'h0A);
    is_space = (rx_data == 8'h20);
    // Letters share the low nibble 1..6 in both cases, so +9 maps them to 10..15.
    if (rx_data <= 8'h39) nib = rx_data[3:0];
    else                  nib = rx_data[3:0] + 4'd9;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      acc          <= '0;
      count        <= '0;
      word_out     <= '0;
      word_nibbles <= '0;
      word_valid   <= 1'b0;
      err_pulse    <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_valid) begin
            if (is_hex) begin
              acc   <= DATA_W'(nib);
              count <= NIB_W'(1);
              state <= ACCUM;
            end else if (!is_term && !is_space) begin
              state <= DISCARD;
            end
          end
        end
        ACCUM: begin
          if (rx_valid) begin
            if (is_hex) begin
              // Overflow is tested before shifting so the accumulator never wraps.
              if (count == NIB_W'(DIGITS)) begin
                state <= DISCARD;
              end else begin
                acc   <= {acc[DATA_W-5:0], nib};
                count <= count + NIB_W'(1);
              end
            end else if (is_term) begin
              word_out     <= acc;
              word_nibbles <= count;
              word_valid   <= 1'b1;
              state        <= HOLD;
            end else if (!is_space) begin
              state <= DISCARD;
            end
          end
        end
        DISCARD: begin
          if (rx_valid && is_term) begin
            err_pulse <= 1'b1;
            acc       <= '0;
            count     <= '0;
            state     <= IDLE;
          end
        end
        HOLD: begin
          if (rx_valid) overrun <= 1'b1;
          if (word_ready) begin
            word_valid <= 1'b0;
            acc        <= '0;
            count      <= '0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef HEX_ASSEMBLER_ECHO_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      echo_data  <= '0;
      echo_valid <= 1'b0;
    end else begin
      echo_valid <= rx_valid;
      if (rx_valid) begin
        if ((rx_data >= 8'h61) && (rx_data <= 8'h66)) echo_data <= rx_data - 8'h20;
        else                                          echo_data <= rx_data;
      end
    end
  end
`else
  assign echo_data  = '0;
  assign echo_valid = 1'b0;
`endif

endmodule
